ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/ctrl_decode.sv | 72 +++++++
 rtl/ctrl_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_pipe control-signal pipeline: opcodes,
// ALU operation encodings and the per-lane control bundle layout.
package ctrl_pkg;

    localparam int CTRL_W = 13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010
    } alu_op_e;

    localparam int B_VALID    = 0;
    localparam int B_ALUOP_LO = 1;
    localparam int B_ALUOP_HI = 3;
    localparam int B_REGDST   = 4;
    localparam int B_BRANCH   = 5;
    localparam int B_MEMREAD  = 6;
    localparam int B_MEMTOREG = 7;
    localparam int B_MEMWRITE = 8;
    localparam int B_ALUSRC   = 9;
    localparam int B_REGWRITE = 10;
    localparam int B_BNE      = 11;
    localparam int B_BGTZ     = 12;

    // Declared MSB first so that the packed layout matches the B_* indices.
    typedef struct packed {
        logic    bgtz;
        logic    bne;
        logic    reg_write;
        logic    alu_src;
        logic    mem_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    branch;
        logic    reg_dst;
        alu_op_e alu_op;
        logic    valid;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational single-lane decoder: opcode + valid -> control bundle and an
// illegal-opcode flag. Invalid or undecodable lanes yield an all-zero bundle.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic              valid_i,
    input  logic [OP_W-1:0]   opcode_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o
);

    ctrl_t ctrl;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        ctrl      = '0;
        illegal_o = 1'b0;
        if (valid_i) begin
            unique case (opcode_i)
                OP_W'(OP_RTYPE): begin
                    ctrl.valid     = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_RTYPE;
                end
                OP_W'(OP_LW): begin
                    ctrl.valid      = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.alu_op     = ALU_ADD;
                end
                OP_W'(OP_SW): begin
                    ctrl.valid     = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                end
                OP_W'(OP_BEQ): begin
                    ctrl.valid  = 1'b1;
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                end
                OP_W'(OP_BNE): begin
                    ctrl.valid  = 1'b1;
                    ctrl.branch = 1'b1;
                    ctrl.bne    = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                end
                OP_W'(OP_BGTZ): begin
                    ctrl.valid  = 1'b1;
                    ctrl.branch = 1'b1;
                    ctrl.bgtz   = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                end
                OP_W'(OP_ADDI): begin
                    ctrl.valid     = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

    assign ctrl_o = ctrl;

endmodule

// File: rtl/ctrl_pipe.sv
// Multi-lane control pipeline ID -> EX -> MEM -> WB with stall/flush bubbles.
// Define CTRL_ILLEGAL_CNT_EN to add the saturating illegal-opcode counter port.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int LANES = 2,
    parameter int OP_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        id_valid,
    input  logic [LANES*OP_W-1:0]   id_opcode,
    input  logic                    stall,
    input  logic                    flush,
    output logic [LANES*CTRL_W-1:0] ex_ctrl,
    output logic [LANES*CTRL_W-1:0] mem_ctrl,
    output logic [LANES*CTRL_W-1:0] wb_ctrl,
`ifdef CTRL_ILLEGAL_CNT_EN
    output logic [LANES-1:0]        id_illegal,
    output logic [15:0]             illegal_cnt
`else
    output logic [LANES-1:0]        id_illegal
`endif
);

    logic [LANES*CTRL_W-1:0] id_ctrl;
    logic [LANES*CTRL_W-1:0] ex_q,  ex_d;
    logic [LANES*CTRL_W-1:0] mem_q, mem_d;
    logic [LANES*CTRL_W-1:0] wb_q,  wb_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ctrl_decode #(.OP_W(OP_W)) u_decode (
            .valid_i   (id_valid[l]),
            .opcode_i  (id_opcode[l*OP_W +: OP_W]),
            .ctrl_o    (id_ctrl[l*CTRL_W +: CTRL_W]),
            .illegal_o (id_illegal[l])
        );
    end

    // Flush kills both EX and MEM entries and dominates stall; WB always drains.
    always_comb begin
        ex_d  = id_ctrl;
        mem_d = ex_q;
        wb_d  = mem_q;
        if (flush) begin
            ex_d  = '0;
            mem_d = '0;
        end else if (stall) begin
            ex_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_ctrl  = ex_q;
    assign mem_ctrl = mem_q;
    assign wb_ctrl  = wb_q;

`ifdef CTRL_ILLEGAL_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, cnt_q} + 17'($countones(id_illegal));
        cnt_d   = cnt_q;
        if (!(stall || flush)) begin
            cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;
`endif

endmodule
